// File: rtl/fusion_issue_queue.sv
// Pair-accepting, single-issue FIFO between fusion scan and issue.
// Optional macro FUSION_QUEUE_PERF_EN adds the fused_cnt_o dequeue counter.
package fusion_issue_queue_pkg;
    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [1:0]  is_fusion;
        logic        ex;
    } scoreboard_entry_t;
endpackage

module fusion_issue_queue #(
    parameter type scoreboard_entry_t = fusion_issue_queue_pkg::scoreboard_entry_t,
    parameter int  DEPTH              = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  scoreboard_entry_t [1:0]       instr_i,
    input  logic [1:0]                    valid_i,
    output logic                          ready_o,
    output scoreboard_entry_t             issue_instr_o,
    output logic                          issue_valid_o,
    input  logic                          issue_ack_i,
`ifdef FUSION_QUEUE_PERF_EN
    output logic [31:0]                   fused_cnt_o,
`endif
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        popcount2 = {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    scoreboard_entry_t mem_r [DEPTH];
    logic [PW-1:0]     rptr_r;
    logic [PW-1:0]     wptr_r;
    logic [CW-1:0]     count_r;

    logic [PW-1:0]     wptr_p1_s;
    logic [PW-1:0]     wptr_next_s;
    logic [PW-1:0]     rptr_next_s;
    logic [CW-1:0]     count_next_s;
    logic [1:0]        enq_n_s;
    logic              deq_s;
    logic              ready_s;
    logic              issue_valid_s;

    assign wptr_p1_s     = wptr_r + PW'(1);
    // Acceptance depends only on registered occupancy so a pair is never split.
    assign ready_s       = ((DEPTH_C - count_r) >= CW'(2));
    assign issue_valid_s = (count_r != CW'(0));

    assign ready_o       = ready_s;
    assign issue_valid_o = issue_valid_s;
    assign issue_instr_o = mem_r[rptr_r];
    assign count_o       = count_r;

    // Enqueue/dequeue amounts and next pointer/count values.
    always_comb begin
        enq_n_s      = 2'd0;
        deq_s        = 1'b0;
        wptr_next_s  = wptr_r;
        rptr_next_s  = rptr_r;
        count_next_s = count_r;
        if (ready_s) begin
            enq_n_s = popcount2(valid_i);
        end else begin
            enq_n_s = 2'd0;
        end
        deq_s        = issue_valid_s & issue_ack_i;
        wptr_next_s  = wptr_r + PW'(enq_n_s);
        rptr_next_s  = rptr_r + PW'(deq_s);
        count_next_s = count_r + CW'(enq_n_s) - CW'(deq_s);
    end

    // Pointer and occupancy state; flush behaves exactly like reset here.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            rptr_r  <= rptr_next_s;
            wptr_r  <= wptr_next_s;
            count_r <= count_next_s;
        end
    end

    // Storage writes; a lone slot-1 entry is compacted into the next free slot.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && ready_s) begin
            case (valid_i)
                2'b11: begin
                    mem_r[wptr_r]    <= instr_i[0];
                    mem_r[wptr_p1_s] <= instr_i[1];
                end
                2'b01:   mem_r[wptr_r] <= instr_i[0];
                2'b10:   mem_r[wptr_r] <= instr_i[1];
                default: ;
            endcase
        end
    end

`ifdef FUSION_QUEUE_PERF_EN
    logic [31:0] fused_cnt_r;
    logic        fused_deq_s;

    assign fused_deq_s = deq_s & (issue_instr_o.is_fusion != 2'b00);
    assign fused_cnt_o = fused_cnt_r;

    // Saturating count of fused entries issued; survives flush, not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fused_cnt_r <= 32'd0;
        end else if (fused_deq_s && (fused_cnt_r != 32'hFFFF_FFFF)) begin
            fused_cnt_r <= fused_cnt_r + 32'd1;
        end else begin
            fused_cnt_r <= fused_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_fusion_issue_queue.sv
// Directed self-checking bench for fusion_issue_queue (DEPTH=4).
module tb_fusion_issue_queue;
    import fusion_issue_queue_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    scoreboard_entry_t [1:0] instr_i;
    logic [1:0]              valid_i;
    logic                    ready_o;
    scoreboard_entry_t       issue_instr_o;
    logic                    issue_valid_o;
    logic                    issue_ack_i;
    logic [2:0]              count_o;
`ifdef FUSION_QUEUE_PERF_EN
    logic [31:0]             fused_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fusion_issue_queue #(.DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .instr_i       (instr_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .issue_instr_o (issue_instr_o),
        .issue_valid_o (issue_valid_o),
        .issue_ack_i   (issue_ack_i),
`ifdef FUSION_QUEUE_PERF_EN
        .fused_cnt_o   (fused_cnt_o),
`endif
        .count_o       (count_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic scoreboard_entry_t mk(input logic [15:0] pc, input logic [1:0] fus);
        scoreboard_entry_t e;
        e.pc        = pc;
        e.op        = pc[7:0];
        e.is_fusion = fus;
        e.ex        = pc[0];
        return e;
    endfunction

    task automatic push(input logic [1:0] v, input scoreboard_entry_t e0, input scoreboard_entry_t e1);
        valid_i    = v;
        instr_i[0] = e0;
        instr_i[1] = e1;
        tick();
        valid_i    = 2'b00;
    endtask

    task automatic ack_one();
        issue_ack_i = 1'b1;
        tick();
        issue_ack_i = 1'b0;
    endtask

    task automatic chk_head(input string tag, input scoreboard_entry_t e);
        check_val(tag, 32'(issue_instr_o), 32'(e));
    endtask

    scoreboard_entry_t ea, eb, ec, ed, ee, ex, ey, ep, eq, er, es, et, eu, ev, ew;

    initial begin
        ea = mk(16'h1A01, 2'b00); eb = mk(16'h1B02, 2'b11); ec = mk(16'h1C03, 2'b01);
        ed = mk(16'h1D04, 2'b00); ee = mk(16'h1E05, 2'b10); ex = mk(16'h2A07, 2'b10);
        ey = mk(16'h2B08, 2'b00); ep = mk(16'h3A09, 2'b01); eq = mk(16'h3B0A, 2'b11);
        er = mk(16'h4A0B, 2'b00); es = mk(16'h4B0C, 2'b00); et = mk(16'h4C0D, 2'b00);
        eu = mk(16'h4D0E, 2'b00); ev = mk(16'h5A0F, 2'b00); ew = mk(16'h5B10, 2'b01);

        rst_i = 1'b1; flush_i = 1'b0; valid_i = 2'b00; issue_ack_i = 1'b0;
        instr_i[0] = '0; instr_i[1] = '0;
        tick(); tick();
        rst_i = 1'b0;
        check_val("rst_count", 32'(count_o), 32'd0);
        check_val("rst_valid", 32'(issue_valid_o), 32'd0);
        check_val("rst_ready", 32'(ready_o), 32'd1);

        // Pair in, then drain.
        push(2'b11, ea, eb);
        check_val("pair_count", 32'(count_o), 32'd2);
        check_val("pair_valid", 32'(issue_valid_o), 32'd1);
        chk_head("pair_head_a", ea);
        ack_one();
        chk_head("pair_head_b", eb);
        check_val("pair_count1", 32'(count_o), 32'd1);
        ack_one();
        check_val("drain_count", 32'(count_o), 32'd0);
        ack_one();
        check_val("empty_ack_count", 32'(count_o), 32'd0);
        check_val("empty_ack_valid", 32'(issue_valid_o), 32'd0);

        // Fill to DEPTH-1; further pair is refused.
        push(2'b11, ea, eb);
        push(2'b01, ec, ed);
        check_val("fill_count", 32'(count_o), 32'd3);
        check_val("fill_ready", 32'(ready_o), 32'd0);
        push(2'b11, ed, ee);
        check_val("refuse_count", 32'(count_o), 32'd3);
        chk_head("order_a", ea);
        ack_one();
        chk_head("order_b", eb);
        check_val("order_ready", 32'(ready_o), 32'd1);
        ack_one();
        chk_head("order_c", ec);
        ack_one();
        check_val("order_count", 32'(count_o), 32'd0);
        check_val("order_ready0", 32'(ready_o), 32'd1);

        // Slot-1-only entry is compacted.
        push(2'b10, ed, ex);
        check_val("compact_count", 32'(count_o), 32'd1);
        chk_head("compact_head", ex);
        ack_one();

        // Move pointers to 3, then a pair straddles the wrap.
        push(2'b01, ey, ea);
        ack_one();
        push(2'b11, ep, eq);
        check_val("wrap_count2", 32'(count_o), 32'd2);
        chk_head("wrap_p", ep);
        ack_one();
        check_val("wrap_count1", 32'(count_o), 32'd1);
        chk_head("wrap_q", eq);
        ack_one();
        check_val("wrap_count0", 32'(count_o), 32'd0);

        // Simultaneous enqueue and dequeue, then flush with competing traffic.
        push(2'b11, er, es);
        issue_ack_i = 1'b1;
        push(2'b11, et, eu);
        issue_ack_i = 1'b0;
        check_val("simul_count", 32'(count_o), 32'd3);
        chk_head("simul_head", es);
        flush_i = 1'b1; issue_ack_i = 1'b1;
        push(2'b11, ev, ew);
        flush_i = 1'b0; issue_ack_i = 1'b0;
        check_val("flush_count", 32'(count_o), 32'd0);
        check_val("flush_valid", 32'(issue_valid_o), 32'd0);
        check_val("flush_ready", 32'(ready_o), 32'd1);
        push(2'b11, ev, ew);
        chk_head("post_flush_head", ev);

        // Reset mid-operation.
        rst_i = 1'b1;
        push(2'b11, ea, eb);
        rst_i = 1'b0;
        check_val("midrst_count", 32'(count_o), 32'd0);
        check_val("midrst_valid", 32'(issue_valid_o), 32'd0);

`ifdef FUSION_QUEUE_PERF_EN
        check_val("perf_rst", fused_cnt_o, 32'd0);
        push(2'b11, mk(16'h6001, 2'b11), mk(16'h6002, 2'b00));
        push(2'b01, mk(16'h6003, 2'b01), ea);
        ack_one();
        check_val("perf_1", fused_cnt_o, 32'd1);
        ack_one();
        check_val("perf_1b", fused_cnt_o, 32'd1);
        ack_one();
        check_val("perf_2", fused_cnt_o, 32'd2);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        check_val("perf_flush", fused_cnt_o, 32'd2);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check_val("perf_clear", fused_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
